// File: rtl/axi_cdc_dst_chan.sv
// Destination (reader) half of one AXI channel's gray-pointer CDC FIFO.
// Synchronizes the write pointer, reads the entry at the read pointer and presents it on valid/ready.
module axi_cdc_dst_chan #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2
) (
    input  logic                               dst_clk_i,
    input  logic                               dst_rst_i,
    input  logic [(2**LogDepth)*DataWidth-1:0] async_data_i,
    input  logic [LogDepth:0]                  async_wptr_i,
    output logic [LogDepth:0]                  async_rptr_o,
    output logic [DataWidth-1:0]               dst_data_o,
    output logic                               dst_valid_o,
    input  logic                               dst_ready_i,
    output logic [LogDepth:0]                  occupancy_o
);
    localparam int unsigned Depth = 2**LogDepth;
    typedef logic [LogDepth:0] ptr_t;

    ptr_t                 wptr_sync_q [SyncStages];
    ptr_t                 wptr_sync_gray;
    ptr_t                 wptr_sync_bin;
    ptr_t                 rptr_bin;
    ptr_t                 rptr_gray;
    ptr_t                 rptr_bin_next;
    logic [DataWidth-1:0] entries [Depth];
    logic                 fifo_empty;
    logic                 load;

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[LogDepth] = gray[LogDepth];
        for (int i = int'(LogDepth) - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Plain flop chain; nothing may sit between stages or the gray property is lost.
    always_ff @(posedge dst_clk_i or posedge dst_rst_i) begin
        if (dst_rst_i) begin
            for (int i = 0; i < int'(SyncStages); i++) begin
                wptr_sync_q[i] <= '0;
            end
        end else begin
            wptr_sync_q[0] <= async_wptr_i;
            for (int i = 1; i < int'(SyncStages); i++) begin
                wptr_sync_q[i] <= wptr_sync_q[i-1];
            end
        end
    end

    assign wptr_sync_gray = wptr_sync_q[SyncStages-1];
    assign wptr_sync_bin  = gray2bin(wptr_sync_gray);

    for (genvar k = 0; k < int'(Depth); k++) begin : g_entry
        assign entries[k] = async_data_i[k*DataWidth +: DataWidth];
    end

    assign fifo_empty    = (wptr_sync_gray == rptr_gray);
    assign load          = !fifo_empty && (!dst_valid_o || dst_ready_i);
    assign rptr_bin_next = rptr_bin + ptr_t'(1);

    // Gray copy is its own register so the returned pointer leaves straight from a flop.
    always_ff @(posedge dst_clk_i or posedge dst_rst_i) begin
        if (dst_rst_i) begin
            rptr_bin    <= '0;
            rptr_gray   <= '0;
            dst_valid_o <= 1'b0;
            dst_data_o  <= '0;
        end else if (load) begin
            rptr_bin    <= rptr_bin_next;
            rptr_gray   <= rptr_bin_next ^ (rptr_bin_next >> 1);
            dst_valid_o <= 1'b1;
            dst_data_o  <= entries[rptr_bin[LogDepth-1:0]];
        end else if (dst_valid_o && dst_ready_i) begin
            dst_valid_o <= 1'b0;
        end
    end

    assign async_rptr_o = rptr_gray;
    assign occupancy_o  = wptr_sync_bin - rptr_bin;

`ifndef SYNTHESIS
    assert property (@(posedge dst_clk_i) disable iff (dst_rst_i)
        $countones(wptr_sync_gray ^ $past(wptr_sync_gray)) <= 1)
        else $error("wptr_sync_gray changed by more than one bit");
    assert property (@(posedge dst_clk_i) disable iff (dst_rst_i)
        occupancy_o <= ptr_t'(Depth))
        else $error("occupancy above depth");
    assert property (@(posedge dst_clk_i) disable iff (dst_rst_i)
        !$isunknown(dst_valid_o))
        else $error("dst_valid_o unknown");
`endif

endmodule

// File: tb/tb_axi_cdc_dst_chan.sv
// Bench for axi_cdc_dst_chan: directed scenarios plus a randomized stream
// checked against a queue model of the FIFO contents.
module tb_axi_cdc_dst_chan;
    localparam int DW = 8;
    localparam int LD = 1;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [1:0]  wptr;
    logic [1:0]  rptr;
    logic [7:0]  dout;
    logic        valid;
    logic        ready;
    logic [1:0]  occ;

    int checks = 0;
    int errors = 0;
    int wbin;
    logic [7:0] model_q [$];

    always #5 clk = ~clk;

    axi_cdc_dst_chan #(
        .DataWidth (DW),
        .LogDepth  (LD),
        .SyncStages(SS)
    ) dut (
        .dst_clk_i   (clk),
        .dst_rst_i   (rst),
        .async_data_i(data),
        .async_wptr_i(wptr),
        .async_rptr_o(rptr),
        .dst_data_o  (dout),
        .dst_valid_o (valid),
        .dst_ready_i (ready),
        .occupancy_o (occ)
    );

    function automatic logic [1:0] to_gray(input int b);
        logic [1:0] x;
        x = b[1:0];
        return x ^ (x >> 1);
    endfunction

    function automatic int from_gray(input logic [1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < 2; i++) r[i] = ^(g >> i);
        return r;
    endfunction

    // Source may write only while fewer than 2 entries are unread.
    function automatic bit src_full();
        return ((wbin - from_gray(rptr)) & 3) >= 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        data[(wbin % 2)*8 +: 8] = v;
        wbin++;
        wptr = to_gray(wbin);
        model_q.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wptr = 2'b00;
        wbin = 0;
        data = '0;
        ready = 1'b0;
        model_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // With ready high this cycle, a valid beat is consumed at the next edge.
    task automatic take_beat(input string tag);
        check({tag, "_beat_expected"}, 32'(model_q.size() > 0), 1);
        if (model_q.size() > 0) begin
            check({tag, "_data"}, dout, model_q.pop_front());
        end
    endtask

    initial begin
        int beats;
        int next;
        bit hold;
        logic [7:0] held;

        // 1. reset with a nonzero write pointer driven
        rst = 1'b1; wptr = 2'b11; data = '0; ready = 1'b0; wbin = 0;
        step(); step();
        check("rst_valid", valid, 0);
        check("rst_rptr", rptr, 2'b00);
        check("rst_data", dout, 8'h00);
        wptr = 2'b00;
        step();
        rst = 1'b0;
        step();

        // 2. single beat and latency
        ready = 1'b1;
        push(8'hA5);
        step(); step();
        check("lat_early_valid", valid, 0);
        step();
        check("single_valid", valid, 1);
        check("single_data", dout, 8'hA5);
        check("single_rptr", rptr, 2'b01);
        step();
        check("single_pop_valid", valid, 0);
        check("single_pop_occ", occ, 0);

        // 3. backpressure
        do_reset();
        push(8'h11);
        step();
        push(8'h22);
        repeat (4) step();
        check("bp_valid", valid, 1);
        check("bp_data", dout, 8'h11);
        check("bp_rptr", rptr, 2'b01);
        check("bp_occ", occ, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", valid, 1);
            check("bp_hold_data", dout, 8'h11);
        end
        ready = 1'b1;
        step();
        check("bp_second_valid", valid, 1);
        check("bp_second_data", dout, 8'h22);
        check("bp_second_rptr", rptr, 2'b11);
        step();
        check("bp_done_valid", valid, 0);
        check("bp_done_rptr", rptr, 2'b11);
        check("bp_done_occ", occ, 0);

        // 4. wrap-around stream 1..6
        do_reset();
        ready = 1'b1;
        beats = 0;
        next = 1;
        for (int c = 0; c < 60; c++) begin
            if (valid) begin
                take_beat("wrap");
                beats++;
            end
            if (next <= 6 && !src_full()) begin
                push(8'(next));
                next++;
            end
            step();
        end
        check("wrap_beats", beats, 6);
        check("wrap_rptr", rptr, 2'b11);
        check("wrap_model_empty", model_q.size(), 0);
        check("wrap_valid", valid, 0);

        // 5. mid-operation reset
        do_reset();
        ready = 1'b1;
        push(8'h31);
        step();
        push(8'h32);
        repeat (6) step();
        ready = 1'b0;
        push(8'h33);
        repeat (3) step();
        check("mid_pre_valid", valid, 1);
        check("mid_pre_rptr", rptr, 2'b10);
        check("mid_pre_data", dout, 8'h33);
        rst = 1'b1; wptr = 2'b00; wbin = 0; model_q.delete();
        #1;
        check("mid_async_valid", valid, 0);
        check("mid_async_rptr", rptr, 2'b00);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_quiet_valid", valid, 0);
        end
        push(8'h44);
        step(); step();
        check("mid_lat_early", valid, 0);
        step();
        check("mid_resume_valid", valid, 1);
        check("mid_resume_data", dout, 8'h44);

        // 6. idle ready on an empty FIFO
        ready = 1'b1;
        step();
        check("idle_start_valid", valid, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_rptr", rptr, 2'b01);
            check("idle_valid", valid, 0);
            check("idle_occ", occ, 0);
        end

        // 7. randomized traffic against the queue model
        do_reset();
        hold = 1'b0;
        held = '0;
        for (int c = 0; c < 400; c++) begin
            if (hold) begin
                check("rnd_hold_valid", valid, 1);
                check("rnd_hold_data", dout, held);
            end
            check("rnd_occ_bound", 32'(occ <= 2'd2), 1);
            ready = ($urandom_range(0, 2) != 0);
            if (valid && ready) take_beat("rnd");
            hold = valid && !ready;
            held = dout;
            if ($urandom_range(0, 2) != 0 && !src_full()) push(8'($urandom));
            step();
        end
        ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (valid) take_beat("drain");
            step();
        end
        check("drain_model_empty", model_q.size(), 0);
        check("drain_valid", valid, 0);
        check("drain_occ", occ, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
